// File: rtl/io_pkg.sv
// Shared defaults for the board-input debouncer: channel counts and synchronizer depth.
package io_pkg;
    localparam int NKEYS_DEF   = 4;
    localparam int NSW_DEF     = 10;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/input_debouncer_if.sv
// Board-input bundle: raw levels and clear strobes in, debounced levels and press flags out.
// master drives the raw side (board/bench), slave is the debouncer.
interface input_debouncer_if #(
    parameter int NKEYS = io_pkg::NKEYS_DEF,
    parameter int NSW   = io_pkg::NSW_DEF
);
    logic [NKEYS-1:0] key_raw;
    logic [NKEYS-1:0] key_evt_clr;
    logic [NSW-1:0]   sw_raw;
    logic [NKEYS-1:0] key_out;
    logic [NKEYS-1:0] key_evt;
    logic [NSW-1:0]   sw_out;

    modport master (
        output key_raw, key_evt_clr, sw_raw,
        input  key_out, key_evt, sw_out
    );
    modport slave (
        input  key_raw, key_evt_clr, sw_raw,
        output key_out, key_evt, sw_out
    );
endinterface

// File: rtl/debounce_channel.sv
// One channel: synchronizer, stability counter and debounced level flop.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clocks from a clean raw edge; no backpressure.
module debounce_channel
    import io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNT_BITS        = 20,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw};
        cnt_d  = '0;
        deb_d  = deb_q;
        // Any cycle of agreement restarts the count, so bounces never accumulate.
        if (synced != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            cnt_q  <= '0;
            deb_q  <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign deb = deb_q;
endmodule

// File: rtl/input_debouncer.sv
// Debounces all board buttons (active-low) and switches, and latches sticky key-press flags.
// Latency: 2 + DEBOUNCE_CYCLES clocks per level change, press flag one clock later; no backpressure.
module input_debouncer
    import io_pkg::*;
#(
    parameter int NKEYS           = NKEYS_DEF,
    parameter int NSW             = NSW_DEF,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_BITS        = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input_debouncer_if.slave     io
);
    logic [NKEYS-1:0] key_deb;
    logic [NSW-1:0]   sw_deb;
    logic [NKEYS-1:0] key_prev_q, key_prev_d;
    logic [NKEYS-1:0] evt_q, evt_d;
    logic [NKEYS-1:0] key_press;

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_BITS        (CNT_BITS),
            .RESET_VAL       (1'b1)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .raw   (io.key_raw[i]),
            .deb   (key_deb[i])
        );
    end

    for (genvar i = 0; i < NSW; i++) begin : g_sw
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_BITS        (CNT_BITS),
            .RESET_VAL       (1'b0)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .raw   (io.sw_raw[i]),
            .deb   (sw_deb[i])
        );
    end

    // Press is a 1->0 edge of the debounced level; a set beats a same-cycle clear.
    always_comb begin
        key_press  = key_prev_q & ~key_deb;
        key_prev_d = key_deb;
        evt_d      = (evt_q & ~io.key_evt_clr) | key_press;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_q <= '1;
            evt_q      <= '0;
        end else begin
            key_prev_q <= key_prev_d;
            evt_q      <= evt_d;
        end
    end

    assign io.key_out = key_deb;
    assign io.sw_out  = sw_deb;
    assign io.key_evt = evt_q;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=4, CNT_BITS=3; inputs driven and outputs sampled on negedge.
module tb_input_debouncer;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    input_debouncer_if #(.NKEYS(4), .NSW(10)) io ();

    input_debouncer #(
        .NKEYS           (4),
        .NSW             (10),
        .DEBOUNCE_CYCLES (4),
        .CNT_BITS        (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        reset          = 1'b1;
        io.key_raw     = 4'hF;
        io.sw_raw      = 10'h000;
        io.key_evt_clr = 4'h0;

        // Reset state
        step(2);
        check("rst_key_out", 16'(io.key_out), 16'h000F);
        check("rst_sw_out",  16'(io.sw_out),  16'h0000);
        check("rst_key_evt", 16'(io.key_evt), 16'h0000);
        reset = 1'b0;
        step(1);
        check("post_rst_key_out", 16'(io.key_out), 16'h000F);
        check("post_rst_sw_out",  16'(io.sw_out),  16'h0000);
        check("post_rst_key_evt", 16'(io.key_evt), 16'h0000);

        // Switch 0 rises: output changes on clock 6, not 5
        io.sw_raw = 10'h001;
        step(5);
        check("sw0_clk5", 16'(io.sw_out), 16'h0000);
        step(1);
        check("sw0_clk6", 16'(io.sw_out), 16'h0001);

        // Key 1 low for only 3 cycles: filtered out
        io.key_raw = 4'b1101;
        step(3);
        io.key_raw = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("key1_bounce_out", 16'(io.key_out), 16'h000F);
        end
        check("key1_bounce_evt", 16'(io.key_evt), 16'h0000);

        // Key 2 held: press, flag next cycle, then write-1-to-clear
        io.key_raw = 4'b1011;
        step(5);
        check("key2_clk5", 16'(io.key_out), 16'h000F);
        step(1);
        check("key2_clk6",     16'(io.key_out), 16'h000B);
        check("key2_evt_lag",  16'(io.key_evt), 16'h0000);
        step(1);
        check("key2_evt_set",  16'(io.key_evt), 16'h0004);
        io.key_evt_clr = 4'b0100;
        step(1);
        io.key_evt_clr = 4'b0000;
        check("key2_evt_clr",  16'(io.key_evt), 16'h0000);

        // Key 2 release must not raise a flag
        io.key_raw = 4'hF;
        step(6);
        check("key2_release_out", 16'(io.key_out), 16'h000F);
        step(2);
        check("key2_release_evt", 16'(io.key_evt), 16'h0000);

        // Key 3: clear strobe coincides with the set; set wins
        io.key_raw = 4'b0111;
        step(6);
        check("key3_out",       16'(io.key_out), 16'h0007);
        check("key3_evt_pre",   16'(io.key_evt), 16'h0000);
        io.key_evt_clr = 4'b1000;
        step(1);
        io.key_evt_clr = 4'b0000;
        check("key3_set_prio",  16'(io.key_evt), 16'h0008);
        step(1);
        check("key3_evt_hold",  16'(io.key_evt), 16'h0008);
        io.key_raw = 4'hF;
        step(8);
        check("key3_release",   16'(io.key_out), 16'h000F);

        // Switch 5 count aborted by reset, then restarts from release
        io.sw_raw = 10'h021;
        step(4);
        reset = 1'b1;
        step(1);
        check("midrst_sw_out",  16'(io.sw_out),  16'h0000);
        check("midrst_key_evt", 16'(io.key_evt), 16'h0000);
        check("midrst_key_out", 16'(io.key_out), 16'h000F);
        step(1);
        reset = 1'b0;
        step(5);
        check("sw5_clk5", 16'(io.sw_out), 16'h0000);
        step(1);
        check("sw5_clk6", 16'(io.sw_out), 16'h0021);
        step(2);
        check("final_key_evt", 16'(io.key_evt), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter NKEYS, default 4, number of push-button channels.
REQ-002 SHALL have parameter NSW, default 10, number of slide-switch channels.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required before an output changes.
REQ-004 SHALL have parameter CNT_BITS, default 20, stability counter width; must satisfy 2^CNT_BITS > DEBOUNCE_CYCLES.
REQ-005 SHALL have port clk  input  1  processor clock from PLL output; sole clock.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port key_raw  input  NKEYS  asynchronous board buttons, active-low (0 = pressed).
REQ-008 SHALL have port sw_raw  input  NSW  asynchronous board switches, active-high.
REQ-009 SHALL have port key_out  output  NKEYS  debounced button levels, active-low; drives processor key_in.
REQ-010 SHALL have port sw_out  output  NSW  debounced switch levels; drives processor sw_in.
REQ-011 SHALL have port key_evt  output  NKEYS  sticky press-event flags, 1 = press seen since last clear.
REQ-012 SHALL have port key_evt_clr  input  NKEYS  write-1-to-clear strobe for key_evt, one bit per key.

Function
REQ-013 SHALL pass every raw input bit through a 2-flop synchronizer before any other logic.
REQ-014 SHALL keep one CNT_BITS counter per channel; counter resets to 0 on any cycle where synchronized value equals debounced output.
REQ-015 SHALL increment counter each cycle synchronized value differs from debounced output.
REQ-016 SHALL load debounced output with synchronized value, and zero counter, on the edge where counter equals DEBOUNCE_CYCLES-1 and values still differ.
REQ-017 SHALL yield latency = 2 + DEBOUNCE_CYCLES clocks from a clean raw edge to output change.
REQ-018 SHALL discard any pulse or bounce shorter than DEBOUNCE_CYCLES synchronized cycles without changing output.
REQ-019 SHALL treat each channel independently; simultaneous changes on multiple channels SHALL not interact.
REQ-020 SHALL set key_evt[i] on the cycle after key_out[i] transitions 1->0; release (0->1) SHALL not set it.
REQ-021 SHALL clear key_evt[i] on the cycle after key_evt_clr[i]=1.
REQ-022 SHALL give set priority when set and clear coincide for the same bit; key_evt[i] remains 1.
REQ-023 SHALL never wrap the counter; saturation cannot occur per REQ-004 and REQ-016.

Reset
REQ-024 SHALL, while reset=1 at a clk edge: key synchronizers and key_out = all 1s, sw synchronizers and sw_out = all 0s, counters = 0, key_evt = 0.
REQ-025 SHALL abort any in-progress count when reset is asserted mid-operation; no output change SHALL result from pre-reset counting.
REQ-026 SHALL, after reset release with switches already on, show sw_out=1 exactly 2 + DEBOUNCE_CYCLES clocks later.

Structure
REQ-027 SHALL place NKEYS, NSW default widths and synchronizer depth constant (2) in shared package io_pkg.
REQ-028 SHALL implement one sub-module debounce_channel (sync, counter, debounced flop, parameter RESET_VAL), instantiated NKEYS+NSW times.
REQ-029 SHALL implement key_evt logic in input_debouncer, outside debounce_channel.
REQ-030 SHALL contain no combinational path from any raw input to any output.

Verification (DEBOUNCE_CYCLES=4, CNT_BITS=3)
REQ-031 SHALL cover: reset with key_raw=4'hF, sw_raw=10'h000 -> key_out=4'hF, sw_out=0, key_evt=0 for first cycle after reset.
REQ-032 SHALL cover: sw_raw[0] 0->1 held -> sw_out[0]=1 exactly 6 clocks after raw change, not at 5.
REQ-033 SHALL cover: key_raw[1] low for 3 cycles then high -> key_out[1] stays 1, key_evt stays 0.
REQ-034 SHALL cover: key_raw[2] held low -> key_out[2]=0 after 6 clocks, key_evt=4'b0100 next cycle; pulse key_evt_clr=4'b0100 -> key_evt=0.
REQ-035 SHALL cover: key_evt set and key_evt_clr asserted same cycle on bit 3 -> key_evt[3]=1 afterwards.
REQ-036 SHALL cover: reset asserted 2 cycles into a sw_raw[5] count, then released with sw_raw[5]=1 -> sw_out[5]=1 exactly 6 clocks after release.
